id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes ADD/SUB/ADDI (plus SH1ADD/SH2ADD/SH3ADD when ID_EX_ZBA_EN
// is defined) into ALU operands, buffered by a two-entry main+skid handshake.
module id_ex_stage #(
  parameter logic [3:0] RESET_ALU_OP = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_rs1_val,
  input  logic [63:0] in_rs2_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
`ifdef ID_EX_ZBA_EN
  localparam logic [3:0] OP_SH1ADD = 4'b0010;
  localparam logic [3:0] OP_SH2ADD = 4'b0011;
  localparam logic [3:0] OP_SH3ADD = 4'b0100;
`endif

  localparam entry_t RESET_ENTRY = '{a: 64'd0, b: 64'd0, op: RESET_ALU_OP,
                                     rd: 5'd0, illegal: 1'b0};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs1_field;
  logic       accept;
  logic       consume;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign unused_rs1_field = ^in_instr[19:15];

  // Illegal slots keep rd but carry zero operands and the reset op code.
  always_comb begin
    dec         = '0;
    dec.op      = RESET_ALU_OP;
    dec.rd      = in_instr[11:7];
    dec.illegal = 1'b1;
    if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000) begin
      dec.a = in_rs1_val; dec.b = in_rs2_val; dec.op = OP_ADD; dec.illegal = 1'b0;
    end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000) begin
      dec.a = in_rs1_val; dec.b = in_rs2_val; dec.op = OP_SUB; dec.illegal = 1'b0;
`ifdef ID_EX_ZBA_EN
    end else if (opcode == 7'b0110011 && funct7 == 7'b0010000 &&
                 (funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110)) begin
      dec.a       = in_rs2_val;
      dec.b       = in_rs1_val;
      dec.illegal = 1'b0;
      case (funct3)
        3'b010:  dec.op = OP_SH1ADD;
        3'b100:  dec.op = OP_SH2ADD;
        default: dec.op = OP_SH3ADD;
      endcase
`endif
    end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
      dec.a = in_rs1_val; dec.b = {{52{in_instr[31]}}, in_instr[31:20]};
      dec.op = OP_ADD; dec.illegal = 1'b0;
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = dec;
          state_d = ONE;
        end
        ONE: begin
          if (accept && consume) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_ENTRY;
      skid_q  <= RESET_ENTRY;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_alu_op  = main_q.op;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_ZBA_EN.
module tb_id_ex_stage;

  localparam logic [3:0] RST_OP = 4'hF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.RESET_ALU_OP(RST_OP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd, input logic ill);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".op"}, 64'(out_alu_op), 64'(op));
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".rd"}, 64'(out_rd), 64'(rd));
    check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
  endtask

  // One instruction through an otherwise idle stage, then drained.
  task automatic single(input string tag, input logic [31:0] instr, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic ill);
    out_ready = 1'b1;
    offer(instr, rs1, rs2);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    expect_out(tag, op, a, b, rd, ill);
    step();
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.a", out_a, 64'd0);
    check("rst.b", out_b, 64'd0);
    check("rst.op", 64'(out_alu_op), 64'(RST_OP));
    check("rst.rd", 64'(out_rd), 64'd0);
    check("rst.ill", 64'(out_illegal), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst.in_ready", 64'(in_ready), 64'd1);

    single("add", 32'h002081B3, 64'd5, 64'd3, 4'h0, 64'd5, 64'd3, 5'd3, 1'b0);
    single("sub", 32'h40208133, 64'd100, 64'd30, 4'h1, 64'd100, 64'd30, 5'd2, 1'b0);
`ifdef ID_EX_ZBA_EN
    single("sh3add", 32'h2020E1B3, 64'd2, 64'd10, 4'h4, 64'd10, 64'd2, 5'd3, 1'b0);
    single("sh1add", 32'h2020A1B3, 64'd7, 64'd9, 4'h2, 64'd9, 64'd7, 5'd3, 1'b0);
`else
    single("sh3add", 32'h2020E1B3, 64'd2, 64'd10, RST_OP, 64'd0, 64'd0, 5'd3, 1'b1);
    single("sh1add", 32'h2020A1B3, 64'd7, 64'd9, RST_OP, 64'd0, 64'd0, 5'd3, 1'b1);
`endif
    single("addi", 32'hFFF00093, 64'd0, 64'd77, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0);
    single("addi_pos", 32'h00510113, 64'd40, 64'd0, 4'h0, 64'd40, 64'd5, 5'd2, 1'b0);
    single("xor_ill", 32'h0020C1B3, 64'd4, 64'd6, RST_OP, 64'd0, 64'd0, 5'd3, 1'b1);
    single("mul_ill", 32'h022081B3, 64'd4, 64'd6, RST_OP, 64'd0, 64'd0, 5'd3, 1'b1);

    // Streaming: accept+consume in ONE replaces main.
    out_ready = 1'b1;
    offer(32'h002081B3, 64'd8, 64'd9);
    step();
    expect_out("strm0", 4'h0, 64'd8, 64'd9, 5'd3, 1'b0);
    offer(32'h40208133, 64'd50, 64'd20);
    step();
    in_valid = 1'b0;
    expect_out("strm1", 4'h1, 64'd50, 64'd20, 5'd2, 1'b0);
    step();
    check("strm.drained", 64'(out_valid), 64'd0);

    // Backpressure: three offers, two accepted, order preserved.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'd1, 64'd2);
    check("bp.rdy0", 64'(in_ready), 64'd1);
    step();
    offer(32'h002081B3, 64'd11, 64'd12);
    check("bp.rdy1", 64'(in_ready), 64'd1);
    step();
    offer(32'h002081B3, 64'd21, 64'd22);
    check("bp.rdy2", 64'(in_ready), 64'd0);
    step();
    check("bp.rdy2b", 64'(in_ready), 64'd0);
    check("bp.hold.a", out_a, 64'd1);
    check("bp.hold.valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp.first.a", out_a, 64'd1);
    check("bp.first.b", out_b, 64'd2);
    step();
    check("bp.second.valid", 64'(out_valid), 64'd1);
    check("bp.second.a", out_a, 64'd11);
    check("bp.second.b", out_b, 64'd12);
    check("bp.second.in_ready", 64'(in_ready), 64'd1);
    step();
    check("bp.empty", 64'(out_valid), 64'd0);
    check("bp.no_third.a", out_a, 64'd11);

    // Flush from TWO with a simultaneous offer.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'd31, 64'd32);
    step();
    offer(32'h002081B3, 64'd41, 64'd42);
    step();
    check("fl.in_ready_two", 64'(in_ready), 64'd0);
    offer(32'h002081B3, 64'd51, 64'd52);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl.valid", 64'(out_valid), 64'd0);
    check("fl.in_ready", 64'(in_ready), 64'd1);
    step();
    check("fl.stays_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'd61, 64'd62);
    step();
    in_valid = 1'b0;
    check("arst.pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    check("arst.a", out_a, 64'd0);
    check("arst.op", 64'(out_alu_op), 64'(RST_OP));
    #1;
    rst = 1'b0;
    step();
    check("arst.after", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
